// File: rtl/ov7670_axis_framer.sv
// OV7670 pixel stream to AXI4-Stream video framer.
// Tags SOF/EOL, buffers in a FWFT FIFO, drops frames on overflow.
module ov7670_axis_framer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int DEPTH    = 16
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vsync_in,
    input  logic        hsync_in,
    input  logic [31:0] pix_data,
    input  logic        pix_valid,
    input  logic        err_clr,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    output logic [15:0] frame_cnt,
    output logic        overflow,
    output logic        line_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 1);
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(V_ACTIVE);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {WAIT_FRAME, ACTIVE, DROP} state_t;

    state_t        state_q, state_d;
    logic          vs_q;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          sof_q, sof_d;
    logic          eol_q, eol_d;
    logic [15:0]   frame_q, frame_d;
    logic          ovf_q, lerr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wr_q, rd_q;
    logic [33:0]   mem_q [DEPTH];

    logic vs_fall, vs_rise, full, push, pop, push_last, ovf_set, lerr_set;

    assign vs_fall = vs_q & ~vsync_in;
    assign vs_rise = ~vs_q & vsync_in;
    assign full    = (cnt_q == FULL_CNT);
    assign pop     = (cnt_q != '0) && m_axis_tready;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        sof_d     = sof_q;
        eol_d     = eol_q;
        frame_d   = frame_q;
        push      = 1'b0;
        push_last = 1'b0;
        ovf_set   = 1'b0;
        lerr_set  = 1'b0;
        unique case (state_q)
            WAIT_FRAME: begin
                if (vs_fall) begin
                    state_d = ACTIVE;
                    x_d     = '0;
                    y_d     = '0;
                    sof_d   = 1'b1;
                    eol_d   = 1'b0;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    frame_d = frame_q + 16'd1;
                    state_d = WAIT_FRAME;
                end else begin
                    // hsync resolves first so a coincident pixel starts the line
                    if (hsync_in) begin
                        if (x_q != '0 && !eol_q) lerr_set = 1'b1;
                        x_d   = '0;
                        eol_d = 1'b0;
                    end
                    if (pix_valid) begin
                        if (eol_d) begin
                            lerr_set = 1'b1;
                        end else if (y_d < Y_MAX) begin
                            if (full) begin
                                ovf_set = 1'b1;
                                state_d = DROP;
                            end else begin
                                push      = 1'b1;
                                push_last = (x_d == X_LAST);
                                sof_d     = 1'b0;
                                if (push_last) begin
                                    x_d   = '0;
                                    y_d   = y_q + 1'b1;
                                    eol_d = 1'b1;
                                end else begin
                                    x_d = x_d + 1'b1;
                                end
                            end
                        end
                    end
                end
            end
            DROP: begin
                if (vs_rise) state_d = WAIT_FRAME;
            end
            default: state_d = WAIT_FRAME;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) cnt_d = cnt_q + 1'b1;
        else if (!push && pop) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= WAIT_FRAME;
            vs_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            sof_q   <= 1'b1;
            eol_q   <= 1'b0;
            frame_q <= '0;
            ovf_q   <= 1'b0;
            lerr_q  <= 1'b0;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            vs_q    <= vsync_in;
            x_q     <= x_d;
            y_q     <= y_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            frame_q <= frame_d;
            ovf_q   <= ovf_set | (ovf_q & ~err_clr);
            lerr_q  <= lerr_set | (lerr_q & ~err_clr);
            cnt_q   <= cnt_d;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (push && !rst) mem_q[wr_q] <= {pix_data, sof_q, push_last};
    end

    // Head is gated so outputs read as zero whenever the FIFO is empty
    assign m_axis_tvalid = (cnt_q != '0);
    assign m_axis_tdata  = m_axis_tvalid ? mem_q[rd_q][33:2] : '0;
    assign m_axis_tuser  = m_axis_tvalid & mem_q[rd_q][1];
    assign m_axis_tlast  = m_axis_tvalid & mem_q[rd_q][0];
    assign frame_cnt     = frame_q;
    assign overflow      = ovf_q;
    assign line_err      = lerr_q;
endmodule

// File: tb/tb_ov7670_axis_framer.sv
// Scoreboard bench for ov7670_axis_framer with a small geometry.
// Expected beats are queued as pixels are driven and popped per beat.
module tb_ov7670_axis_framer;
    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync_in = 1'b1;
    logic        hsync_in = 1'b0;
    logic [31:0] pix_data = '0;
    logic        pix_valid = 1'b0;
    logic        err_clr = 1'b0;
    logic [31:0] tdata;
    logic        tvalid, tuser, tlast;
    logic        tready = 1'b1;
    logic [15:0] frame_cnt;
    logic        overflow, line_err;

    int n_vec = 0;
    int n_err = 0;
    logic [33:0] exp_q[$];

    ov7670_axis_framer #(.H_ACTIVE(4), .V_ACTIVE(2), .DEPTH(4)) dut (
        .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .hsync_in(hsync_in),
        .pix_data(pix_data), .pix_valid(pix_valid), .err_clr(err_clr),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
        .m_axis_tready(tready), .m_axis_tuser(tuser),
        .m_axis_tlast(tlast), .frame_cnt(frame_cnt),
        .overflow(overflow), .line_err(line_err)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge pclk);
        #1;
    endtask

    task automatic pix(input logic [31:0] d);
        pix_valid = 1'b1;
        pix_data  = d;
        cyc();
        pix_valid = 1'b0;
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic u,
                               input logic l);
        exp_q.push_back({u, l, d});
    endtask

    task automatic hs();
        hsync_in = 1'b1;
        cyc();
        hsync_in = 1'b0;
    endtask

    task automatic vs(input logic v);
        vsync_in = v;
        cyc();
        cyc();
    endtask

    task automatic clr();
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) cyc();
        check(tag, exp_q.size(), 0);
    endtask

    always @(negedge pclk) begin
        if (!rst && tvalid && tready) begin
            if (exp_q.size() == 0)
                check("spurious_beat", {1'b1, tuser, tlast, tdata}, 0);
            else
                check("beat", {tuser, tlast, tdata}, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected done");
        $fatal(1);
    end

    initial begin
        repeat (2) cyc();
        check("rst_tvalid", tvalid, 0);
        check("rst_tuser", tuser, 0);
        check("rst_tlast", tlast, 0);
        check("rst_tdata", tdata, 0);
        check("rst_frame", frame_cnt, 0);
        check("rst_ovf", overflow, 0);
        check("rst_lerr", line_err, 0);
        rst = 1'b0;
        cyc();

        for (int i = 0; i < 10; i++) pix(32'hA0 + i);
        cyc();
        check("pre_vs_tvalid", tvalid, 0);

        // normal frame
        vs(1'b0);
        for (int l = 0; l < 2; l++) begin
            hs();
            for (int i = 0; i < 4; i++) begin
                expect_beat(32'h10 + 4 * l + i, (l == 0 && i == 0), (i == 3));
                pix(32'h10 + 4 * l + i);
            end
        end
        cyc();
        vs(1'b1);
        drain("drain_normal");
        check("frame1", frame_cnt, 1);
        check("ovf_normal", overflow, 0);
        check("lerr_normal", line_err, 0);

        // short line, long line, lines past V_ACTIVE
        vs(1'b0);
        hs();
        for (int i = 0; i < 3; i++) begin
            expect_beat(32'h20 + i, (i == 0), 1'b0);
            pix(32'h20 + i);
        end
        hs();
        check("lerr_short", line_err, 1);
        for (int i = 0; i < 4; i++) begin
            expect_beat(32'h23 + i, 1'b0, (i == 3));
            pix(32'h23 + i);
        end
        clr();
        check("lerr_clr1", line_err, 0);
        hs();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) expect_beat(32'h30 + i, 1'b0, (i == 3));
            pix(32'h30 + i);
        end
        check("lerr_long", line_err, 1);
        clr();
        check("lerr_clr2", line_err, 0);
        hs();
        pix(32'h38);
        pix(32'h39);
        check("lerr_past_v", line_err, 0);
        vs(1'b1);
        drain("drain_lines");
        check("frame2", frame_cnt, 2);

        // back-pressure and overflow
        tready = 1'b0;
        vs(1'b0);
        hs();
        for (int i = 0; i < 4; i++) begin
            expect_beat(32'h40 + i, (i == 0), (i == 3));
            pix(32'h40 + i);
        end
        hs();
        pix(32'h44);
        check("ovf_set", overflow, 1);
        check("lerr_bp", line_err, 0);
        for (int i = 0; i < 3; i++) begin
            check("hold_tvalid", tvalid, 1);
            check("hold_tdata", tdata, 32'h40);
            cyc();
        end
        hs();
        pix(32'h45);
        pix(32'h46);
        vs(1'b1);
        check("frame_drop", frame_cnt, 2);
        tready = 1'b1;
        drain("drain_bp");
        clr();
        check("ovf_clr", overflow, 0);
        vs(1'b0);
        hs();
        for (int i = 0; i < 4; i++) begin
            expect_beat(32'h50 + i, (i == 0), (i == 3));
            pix(32'h50 + i);
        end
        vs(1'b1);
        drain("drain_after_drop");
        check("frame3", frame_cnt, 3);

        // reset mid-frame
        tready = 1'b0;
        vs(1'b0);
        hs();
        for (int i = 0; i < 3; i++) pix(32'h60 + i);
        check("queued_tvalid", tvalid, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("midrst_tvalid", tvalid, 0);
        check("midrst_frame", frame_cnt, 0);
        tready = 1'b1;
        hs();
        for (int i = 0; i < 3; i++) pix(32'h68 + i);
        cyc();
        check("postrst_ignored", tvalid, 0);
        vs(1'b1);
        vs(1'b0);
        hs();
        for (int i = 0; i < 4; i++) begin
            expect_beat(32'h70 + i, (i == 0), (i == 3));
            pix(32'h70 + i);
        end
        vs(1'b1);
        drain("drain_postrst");
        check("frame_postrst", frame_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ov7670_axis_framer.md
Name: ov7670_axis_framer

Overview:
- Downstream neighbour of the OV7670 decoder stage.
- Consumes the decoder's per-pixel 32-bit word stream plus vsync/hsync framing, and emits AXI4-Stream video with tuser = start-of-frame and tlast = end-of-line.
- Buffers pixels in a small FIFO to absorb consumer back-pressure. Drops whole frames cleanly on overflow and reports framing errors.

Parameters:
- H_ACTIVE, 640, pixels per line; tlast is tagged on pixel H_ACTIVE-1.
- V_ACTIVE, 480, lines per frame; lines at index V_ACTIVE and above are discarded.
- DEPTH, 16, FIFO depth in words; must be a power of 2 and at least 4.

Ports:
- pclk  in  1  pixel clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- vsync_in  in  1  camera vsync, level; high = vertical blanking.
- hsync_in  in  1  one-cycle pulse at the start of each line.
- pix_data  in  32  pixel word, sampled when pix_valid=1.
- pix_valid  in  1  one-cycle strobe, one per pixel.
- err_clr  in  1  clears the sticky error flags.
- m_axis_tdata  out  32  pixel word.
- m_axis_tvalid  out  1  output word valid.
- m_axis_tready  in  1  consumer ready.
- m_axis_tuser  out  1  first pixel of frame.
- m_axis_tlast  out  1  last pixel of line.
- frame_cnt  out  16  completed-frame counter; wraps.
- overflow  out  1  sticky: FIFO full on write.
- line_err  out  1  sticky: short or long line seen.

Behaviour:
- Clocking and reset
  - All logic is on posedge pclk.
  - Reset is synchronous, active-high. It takes effect at the next edge, including mid-frame.
  - On reset: state=WAIT_FRAME, FIFO empty, x=0, y=0, sof_pend=1, eol_done=0.
  - On reset, all outputs are 0: tvalid, tuser, tlast, tdata, frame_cnt, overflow, line_err.
- Edge detection
  - vsync_in is registered once into vs_d.
  - vs_fall = vs_d & ~vsync_in.
  - vs_rise = ~vs_d & vsync_in.
- State machine
  - WAIT_FRAME: ignore pix_valid. On vs_fall, go to ACTIVE with x=0, y=0, sof_pend=1, eol_done=0.
  - ACTIVE: on vs_rise, increment frame_cnt and go to WAIT_FRAME. On a push attempt with the FIFO full, set overflow and go to DROP; the pixel is lost.
  - DROP: discard all pixels. On vs_rise, go to WAIT_FRAME without incrementing frame_cnt. The FIFO keeps draining in every state.
- Pixel handling in ACTIVE
  - On hsync_in:
    - If x!=0 and eol_done=0 (short line), set line_err.
    - If y was incremented by a completed line, no further change to y.
    - Otherwise (short line or fresh frame), y is unchanged.
    - Then x=0, eol_done=0.
  - On pix_valid with y<V_ACTIVE and eol_done=0: push {pix_data, sof_pend, x==H_ACTIVE-1}, then clear sof_pend.
    - If x==H_ACTIVE-1: x=0, y=y+1, eol_done=1.
    - Otherwise: x=x+1.
  - On pix_valid with eol_done=1 (long line): discard and set line_err.
  - On pix_valid with y>=V_ACTIVE: discard silently.
  - hsync_in and pix_valid in the same cycle: hsync processing applies first, and the pixel is pixel 0 of the new line.
- FIFO
  - Synchronous, first-word-fall-through, (32+2) bits wide, with a count register of log2(DEPTH)+1 bits.
  - Push is accepted iff count<DEPTH. A pop in the same cycle does not free space for that push.
  - tvalid = count!=0. tdata, tuser and tlast are the head entry.
  - Pop occurs when tvalid&&tready. Simultaneous accepted push and pop leaves count unchanged.
  - Latency: a pixel pushed at edge N is visible on the outputs after edge N, i.e. tvalid is sampled high at edge N+1.
  - tdata, tuser and tlast hold stable while tvalid=1 and tready=0.
  - Read and write pointers wrap modulo DEPTH.
- Errors and counters
  - overflow and line_err are sticky; err_clr clears them at the next edge.
  - A set event takes priority over err_clr in the same cycle.
  - frame_cnt wraps from 0xFFFF to 0.

Test Plan:
- Normal frame, tready=1, H_ACTIVE=4, V_ACTIVE=2: vsync 1→0, then two lines each of hsync followed by 4 pix_valid (data 0x10..0x17), then vsync↑.
  - Required: 8 beats 0x10..0x17.
  - tuser=1 only on 0x10; tlast=1 on 0x13 and 0x17.
  - frame_cnt=1; overflow=0; line_err=0.
- Back-pressure, DEPTH=4, tready=0: push 5 pixels.
  - Required: count holds 4 with tdata=first pixel stable; overflow=1; state=DROP.
  - The rest of the frame is discarded; frame_cnt is not incremented.
  - Next frame after vs_fall: first beat has tuser=1.
- Short line: 3 pixels then hsync.
  - Required: line_err=1; next pixel gets x=0; no tlast was emitted for the short line.
- Long line: 6 pixels between hsyncs with H_ACTIVE=4.
  - Required: 4 beats, the 4th with tlast; pixels 5-6 dropped; line_err=1.
  - err_clr pulse → line_err=0 next cycle.
- Reset mid-frame with 3 words queued: rst pulse.
  - Required: tvalid=0 next cycle; pixels ignored until vs_fall.
  - frame_cnt=0; first post-reset beat has tuser=1.
- Pixels before the first vs_fall after reset: 10 pix_valid strobes.
  - Required: tvalid stays 0.
